// File: rtl/indication_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// indication_pipe_arbiter
//
// Purpose:
//   This block shares one host-bound indication pipe between NUM_REQ sources.
//   A round-robin arbiter picks one source whose payload is pending. The
//   payload is tagged with (source index + 1) and registered into a one-deep
//   output stage that drives the pipe enq method. Tag 0 is reserved and is
//   never emitted.
//
// Ports:
//   CLK           in   1               clock, all logic on the rising edge
//   nRST          in   1               synchronous reset, active-low
//   req_valid     in   NUM_REQ         source i has a message pending
//   req_data      in   NUM_REQ*DATA_W  payload i at [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ         one-hot; source i consumed this cycle
//   pipe_enq_ena  out  1               output message valid (registered)
//   pipe_enq_v    out  TAG_W+DATA_W    {tag, data}
//   pipe_enq_rdy  in   1               pipe accepts the message this cycle
//
// Optional feature, macro INDICATION_PIPE_ARBITER_STATS_EN:
//   stat_grants   out  NUM_REQ*16      per-source transfer counters (wrap)
//   stat_stalls   out  16              cycles with out_valid && !pipe_enq_rdy
// -----------------------------------------------------------------------------
module indication_pipe_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pipe_enq_ena,
    output logic [TAG_W+DATA_W-1:0]   pipe_enq_v,
    input  logic                      pipe_enq_rdy
`ifdef INDICATION_PIPE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_stalls
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic                    out_valid_q, out_valid_d;
    logic [TAG_W+DATA_W-1:0] out_msg_q,   out_msg_d;
    logic [PTR_W-1:0]        rr_ptr_q,    rr_ptr_d;

    logic [DATA_W-1:0]       req_data_arr [NUM_REQ];
    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic                    load_en;
    logic                    do_load;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Scan from rr_ptr upward modulo NUM_REQ; first valid source wins.
    always_comb begin
        logic [PTR_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Output stage can take a new message when empty or draining this cycle.
    // nRST gates the grant so no source is consumed during a reset cycle.
    assign load_en   = !out_valid_q || pipe_enq_rdy;
    assign do_load   = nRST && load_en && grant_found;
    assign req_ready = do_load ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        rr_ptr_d    = rr_ptr_q;
        if (do_load) begin
            // A load replaces any message draining in the same cycle.
            out_valid_d = 1'b1;
            out_msg_d   = {TAG_W'(grant_idx) + TAG_W'(1), req_data_arr[grant_idx]};
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (out_valid_q && pipe_enq_rdy) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign pipe_enq_ena = out_valid_q;
    assign pipe_enq_v   = out_msg_q;

`ifdef INDICATION_PIPE_ARBITER_STATS_EN
    logic [15:0] stat_stalls_q, stat_stalls_d;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_grant
        logic [15:0] grant_cnt_q, grant_cnt_d;

        always_comb begin
            grant_cnt_d = grant_cnt_q;
            if (do_load && (grant_idx == PTR_W'(gi))) begin
                grant_cnt_d = grant_cnt_q + 16'd1;
            end
        end

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                grant_cnt_q <= '0;
            end else begin
                grant_cnt_q <= grant_cnt_d;
            end
        end

        assign stat_grants[gi*16 +: 16] = grant_cnt_q;
    end

    always_comb begin
        stat_stalls_d = stat_stalls_q;
        if (out_valid_q && !pipe_enq_rdy) begin
            stat_stalls_d = stat_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_stalls_q <= '0;
        end else begin
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_stalls = stat_stalls_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
